// File: rtl/beamscaler_gen_if.sv
// Read port of the beam scaler: a one-cycle read strobe with address, answered
// by registered data and a valid flag one cycle later.
interface beamscaler_gen_if #(
    parameter int ADDR_WIDTH = 8
);
    // scal_rd_i is a strobe (no ready): scal_valid_o is high in exactly the
    // cycle after each strobe, and scal_dat_o holds its last value otherwise.
    logic                  scal_rd_i;
    logic [ADDR_WIDTH-1:0] scal_adr_i;
    logic [31:0]           scal_dat_o;
    logic                  scal_valid_o;

    modport master (
        output scal_rd_i,
        output scal_adr_i,
        input  scal_dat_o,
        input  scal_valid_o
    );

    modport slave (
        input  scal_rd_i,
        input  scal_adr_i,
        output scal_dat_o,
        output scal_valid_o
    );
endinterface

// File: rtl/beamscaler_gen.sv
// Per-channel saturating scalers with double-buffered readout: an interval end
// snapshots all channels, copies them serially into the write bank, then swaps.
module beamscaler_gen #(
    parameter int NCHAN      = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic [NCHAN-1:0] count_i,
    input  logic             timer_i,
    beamscaler_gen_if.slave  scal,
    output logic             done_o,
    output logic             write_bank_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_SWAP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [NCHAN-1:0][CNT_WIDTH-1:0] acc_q, acc_d;
    logic [NCHAN-1:0][CNT_WIDTH-1:0] shadow_q, shadow_d;
    logic [NCHAN-1:0]                sat_q, sat_d;
    logic [NCHAN-1:0]                shadow_sat_q, shadow_sat_d;
    logic [1:0][NCHAN-1:0][31:0]     bank_q, bank_d;
    logic [NCHAN-1:0][31:0]          entry;
    logic [ADDR_WIDTH-1:0]           idx_q, idx_d;
    logic                            pending_q, pending_d;
    logic                            overrun_q, overrun_d;
    logic                            wbank_q, wbank_d;
    logic                            done_q, done_d;
    logic                            valid_q, valid_d;
    logic [31:0]                     rdata_q, rdata_d;

    logic trigger;
    logic busy;
    logic in_copy;
    logic in_swap;
    logic copy_last;
    logic status_sel;
    logic overrun_set;

    assign copy_last  = (idx_q == ADDR_WIDTH'(NCHAN - 1));
    assign status_sel = &scal.scal_adr_i;

    // FSM: state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (trigger) state_d = ST_COPY;
            ST_COPY: if (copy_last) state_d = ST_SWAP;
            ST_SWAP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs; a strobe that lands while busy is parked in pending_q
    always_comb begin
        trigger = 1'b0;
        busy    = 1'b1;
        in_copy = 1'b0;
        in_swap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy    = 1'b0;
                trigger = timer_i | pending_q;
            end
            ST_COPY: in_copy = 1'b1;
            ST_SWAP: in_swap = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Trigger-cycle counts start the new interval so no count is lost.
    always_comb begin
        acc_d        = acc_q;
        sat_d        = sat_q;
        shadow_d     = shadow_q;
        shadow_sat_d = shadow_sat_q;
        if (trigger) begin
            shadow_d     = acc_q;
            shadow_sat_d = sat_q;
            sat_d        = '0;
            for (int i = 0; i < NCHAN; i++) begin
                acc_d[i] = CNT_WIDTH'(count_i[i]);
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (count_i[i]) begin
                    if (&acc_q[i]) sat_d[i] = 1'b1;
                    else           acc_d[i] = acc_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        entry = '0;
        for (int i = 0; i < NCHAN; i++) begin
            entry[i][CNT_WIDTH-1:0] = shadow_q[i];
            entry[i][31]            = shadow_sat_q[i];
        end
    end

    always_comb begin
        bank_d = bank_q;
        idx_d  = '0;
        if (in_copy) begin
            for (int i = 0; i < NCHAN; i++) begin
                if (idx_q == ADDR_WIDTH'(i)) bank_d[wbank_q][i] = entry[i];
            end
            idx_d = copy_last ? '0 : idx_q + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        overrun_set = 1'b0;
        if (trigger) begin
            pending_d = 1'b0;
        end else if (busy && timer_i) begin
            if (pending_q) overrun_set = 1'b1;
            else           pending_d   = 1'b1;
        end
        if (scal.scal_rd_i && status_sel) overrun_d = 1'b0;
        if (overrun_set)                  overrun_d = 1'b1;
        wbank_d = wbank_q ^ in_swap;
        done_d  = in_swap;
    end

    // Reads only ever see the read bank, which COPY never touches.
    always_comb begin
        valid_d = scal.scal_rd_i;
        rdata_d = rdata_q;
        if (scal.scal_rd_i) begin
            rdata_d = '0;
            if (status_sel) begin
                rdata_d = {overrun_q, pending_q, wbank_q, busy, 28'b0};
            end else begin
                for (int i = 0; i < NCHAN; i++) begin
                    if (scal.scal_adr_i == ADDR_WIDTH'(i)) rdata_d = bank_q[!wbank_q][i];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            acc_q        <= '0;
            sat_q        <= '0;
            shadow_q     <= '0;
            shadow_sat_q <= '0;
            bank_q       <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            wbank_q      <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            shadow_q     <= shadow_d;
            shadow_sat_q <= shadow_sat_d;
            bank_q       <= bank_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            wbank_q      <= wbank_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign done_o            = done_q;
    assign write_bank_o      = wbank_q;
    assign state_o           = state_q;
    assign scal.scal_dat_o   = rdata_q;
    assign scal.scal_valid_o = valid_q;

endmodule

// File: doc/beamscaler_gen.md
BEAMSCALER_GEN -- requirements
Module: beamscaler_gen

Interface
REQ-001 Parameter NCHAN, default 8: number of scaler channels, 1..(2**ADDR_WIDTH)-1.
REQ-002 Parameter CNT_WIDTH, default 16: accumulator width, 1..31.
REQ-003 Parameter ADDR_WIDTH, default 8: read address width.
REQ-004 wb_clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 wb_rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 count_i  input  NCHAN  per-channel count flags, already synchronous to wb_clk_i, one count per high cycle.
REQ-007 timer_i  input  1  single-cycle interval-end strobe.
REQ-008 scal_rd_i  input  1  read strobe.
REQ-009 scal_adr_i  input  ADDR_WIDTH  read address.
REQ-010 scal_dat_o  output  32  read data.
REQ-011 scal_valid_o  output  1  read data valid.
REQ-012 done_o  output  1  one-cycle pulse: new interval published.
REQ-013 write_bank_o  output  1  bank currently being written; read bank is its inverse.

Function
REQ-014 Each channel SHALL have a CNT_WIDTH accumulator incrementing by one per cycle with its count_i bit high.
REQ-015 An accumulator at all-ones SHALL hold (saturate) and set that channel's sat bit; sat bit clears with the accumulator.
REQ-016 Trigger = timer_i or pending, evaluated only in IDLE; on trigger, all accumulators+sat bits SHALL copy to shadow registers and clear in the same edge; count_i high in the trigger cycle SHALL count into the new interval (accumulator = 1), so no count is lost.
REQ-017 FSM states: IDLE, COPY, SWAP; IDLE->COPY on trigger; COPY stays NCHAN cycles, index k=0..NCHAN-1, writing shadow[k] into bank !read_bank... i.e. bank write_bank_o, entry k; COPY->SWAP after k=NCHAN-1; SWAP->IDLE unconditionally.
REQ-018 In SWAP, write_bank_o SHALL toggle and done_o SHALL assert, both visible the cycle after SWAP; done_o high exactly one cycle.
REQ-019 Trigger at cycle t SHALL yield done_o high at cycle t+NCHAN+2.
REQ-020 timer_i in COPY or SWAP SHALL set pending; pending clears when consumed by IDLE trigger.
REQ-021 timer_i while pending already set (outside IDLE) SHALL set sticky overrun; the extra strobe is discarded.
REQ-022 Bank storage entry = {sat, (31-CNT_WIDTH) zeros, count[CNT_WIDTH-1:0]}.
REQ-023 Read: scal_rd_i at cycle t SHALL give scal_dat_o and scal_valid_o=1 at t+1; scal_valid_o=0 when no read the prior cycle; scal_dat_o holds last value when not reading.
REQ-024 Address < NCHAN SHALL return that entry from read bank (!write_bank_o).
REQ-025 Address all-ones SHALL return status {overrun, pending, write_bank_o, state busy, 28 zeros} MSB-first; reading it clears overrun; a simultaneous overrun set wins over clear.
REQ-026 Other addresses SHALL return 0.
REQ-027 Reads during COPY SHALL return only the stable read bank; never partially-updated data.

Reset
REQ-028 On wb_rst_n_i low: state IDLE, accumulators, sat bits, shadows, both banks, pending, overrun, index cleared; write_bank_o=0, done_o=0, scal_valid_o=0, scal_dat_o=0.
REQ-029 Reset mid-COPY SHALL abort the copy with no bank swap and no done_o pulse.
REQ-030 Logic SHALL resume on first edge after wb_rst_n_i deasserts; reads before first done_o return 0.

Verification
REQ-031 NCHAN=8: ch3 high 100 cycles, timer_i -> done_o 10 cycles later, write_bank_o=1, read adr 3 = 100, other channels 0.
REQ-032 CNT_WIDTH=4: ch0 high 40 cycles, timer -> adr 0 = 0x8000000F (saturated, sat bit).
REQ-033 count_i[1] held high across trigger cycle -> interval N reads exactly cycles before trigger; interval N+1 includes trigger cycle; sum equals total high cycles.
REQ-034 timer_i twice during COPY -> pending serviced, second sets overrun; status read shows bit31=1, next status read bit31=0.
REQ-035 Reads of adr 2 every cycle during COPY -> value constant = previous interval until done_o.
REQ-036 wb_rst_n_i pulsed low mid-COPY -> no done_o, write_bank_o=0, all reads 0.
